// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer feeding the commit stage.
// Optional same-cycle CDB-to-head bypass: define ROB_CDB_BYPASS_EN.
module reorder_buffer #(
   parameter int data_width = 16,
   parameter int addr_width = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  issue_we,
   input  logic [3:0]            issue_opcode,
   input  logic [2:0]            issue_dest,
   input  logic [15:0]           issue_pc,
   input  logic                  issue_predict,
   input  logic                  issue_ready,
   input  logic [data_width-1:0] issue_value,
   output logic [addr_width-1:0] tail_out,
   output logic                  rob_full,
   output logic                  rob_empty,
   input  logic                  cdb_valid,
   input  logic [addr_width-1:0] cdb_tag,
   input  logic [data_width-1:0] cdb_value,
   input  logic                  RE,
   input  logic                  flush,
   output logic [addr_width-1:0] head_addr,
   output logic                  valid_out,
   output logic [3:0]            opcode_out,
   output logic [2:0]            dest_out,
   output logic [data_width-1:0] value_out,
   output logic                  predict_out,
   output logic [15:0]           pc_out
);

   localparam int depth = 2 ** addr_width;
   localparam logic [addr_width:0] full_cnt = (addr_width + 1)'(depth);

   logic [depth-1:0]      busy;
   logic [depth-1:0]      ready;
   logic [3:0]            opcode_q [depth];
   logic [2:0]            dest_q   [depth];
   logic [data_width-1:0] value_q  [depth];
   logic [depth-1:0]      predict_q;
   logic [15:0]           pc_q     [depth];

   logic [addr_width-1:0] head;
   logic [addr_width-1:0] tail;
   logic [addr_width:0]   count;

   logic do_issue;
   logic do_retire;
   logic cdb_hit;

   assign rob_full  = (count == full_cnt);
   assign rob_empty = (count == '0);
   assign do_issue  = issue_we & ~rob_full;
   assign do_retire = RE & ~rob_empty;
   // an issue to the same slot overrides a stale broadcast
   assign cdb_hit   = cdb_valid & busy[cdb_tag]
                    & ~(do_issue & (cdb_tag == tail));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         busy  <= '0;
         ready <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         busy  <= '0;
         ready <= '0;
      end else begin
         if (cdb_hit)
            ready[cdb_tag] <= 1'b1;
         if (do_retire) begin
            busy[head]  <= 1'b0;
            ready[head] <= 1'b0;
            head        <= head + 1'b1;
         end
         if (do_issue) begin
            busy[tail]  <= 1'b1;
            ready[tail] <= issue_ready;
            tail        <= tail + 1'b1;
         end
         unique case ({do_issue, do_retire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // payload carries no meaning unless busy, so it needs no reset
   always_ff @(posedge clk) begin
      if (!flush) begin
         if (cdb_hit)
            value_q[cdb_tag] <= cdb_value;
         if (do_issue) begin
            opcode_q[tail]  <= issue_opcode;
            dest_q[tail]    <= issue_dest;
            value_q[tail]   <= issue_value;
            predict_q[tail] <= issue_predict;
            pc_q[tail]      <= issue_pc;
         end
      end
   end

   assign tail_out    = tail;
   assign head_addr   = head;
   assign opcode_out  = opcode_q[head];
   assign dest_out    = dest_q[head];
   assign predict_out = predict_q[head];
   assign pc_out      = pc_q[head];

`ifdef ROB_CDB_BYPASS_EN
   logic bypass;
   assign bypass    = cdb_valid & (cdb_tag == head) & busy[head];
   assign valid_out = (busy[head] & ready[head]) | bypass;
   assign value_out = bypass ? cdb_value : value_q[head];
`else
   assign valid_out = busy[head] & ready[head];
   assign value_out = value_q[head];
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: fill/wrap, CDB ordering,
// retire, flush, async reset and the optional head bypass.
module tb_reorder_buffer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        issue_we;
   logic [3:0]  issue_opcode;
   logic [2:0]  issue_dest;
   logic [15:0] issue_pc;
   logic        issue_predict;
   logic        issue_ready;
   logic [15:0] issue_value;
   logic [2:0]  tail_out;
   logic        rob_full;
   logic        rob_empty;
   logic        cdb_valid;
   logic [2:0]  cdb_tag;
   logic [15:0] cdb_value;
   logic        RE;
   logic        flush;
   logic [2:0]  head_addr;
   logic        valid_out;
   logic [3:0]  opcode_out;
   logic [2:0]  dest_out;
   logic [15:0] value_out;
   logic        predict_out;
   logic [15:0] pc_out;

   int checks = 0;
   int errors = 0;

   reorder_buffer #(.data_width(16), .addr_width(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .issue_we(issue_we), .issue_opcode(issue_opcode),
      .issue_dest(issue_dest), .issue_pc(issue_pc),
      .issue_predict(issue_predict), .issue_ready(issue_ready),
      .issue_value(issue_value), .tail_out(tail_out),
      .rob_full(rob_full), .rob_empty(rob_empty),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
      .cdb_value(cdb_value), .RE(RE), .flush(flush),
      .head_addr(head_addr), .valid_out(valid_out),
      .opcode_out(opcode_out), .dest_out(dest_out),
      .value_out(value_out), .predict_out(predict_out),
      .pc_out(pc_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      issue_we = 0; issue_opcode = 0; issue_dest = 0;
      issue_pc = 0; issue_predict = 0; issue_ready = 0;
      issue_value = 0; cdb_valid = 0; cdb_tag = 0;
      cdb_value = 0; RE = 0; flush = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [15:0] pc, input logic rdy,
                      input logic [15:0] val);
      issue_we = 1; issue_pc = pc;
      issue_ready = rdy; issue_value = val;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      idle();
      #1 rst_n = 0;
      #2;
      check("rst_empty", rob_empty, 1);
      check("rst_full", rob_full, 0);
      check("rst_valid", valid_out, 0);
      check("rst_head", head_addr, 0);
      check("rst_tail", tail_out, 0);
      tick();
      rst_n = 1;

      for (int i = 0; i < 3; i++) begin
         put(16'h0100 + 16'(2 * i), 1, 16'h0100 + 16'(i));
         tick();
      end
      idle();
      #1;
      check("pre_rst_valid", valid_out, 1);
      check("pre_rst_value", value_out, 16'h0100);
      check("pre_rst_tail", tail_out, 3);
      #2 rst_n = 0;
      #1;
      check("arst_empty", rob_empty, 1);
      check("arst_valid", valid_out, 0);
      check("arst_head", head_addr, 0);
      check("arst_tail", tail_out, 0);
      tick();
      rst_n = 1;

      for (int i = 0; i < 8; i++) begin
         put(16'h0010 + 16'(2 * i), 0, 0);
         issue_opcode = 4'(i);
         issue_dest = 3'(i);
         #1;
         check("fill_tag", tail_out, i);
         tick();
      end
      put(16'hDEAD, 1, 16'hDEAD);
      #1;
      check("full_8", rob_full, 1);
      check("ninth_tail", tail_out, 0);
      tick();
      idle();
      #1;
      check("ninth_full", rob_full, 1);
      check("ninth_head", head_addr, 0);
      check("ninth_pc", pc_out, 16'h0010);
      check("ninth_valid", valid_out, 0);

      cdb_valid = 1; cdb_tag = 0; cdb_value = 16'h1234;
      tick();
      idle();
      #1;
      check("cdb0_valid", valid_out, 1);
      check("cdb0_value", value_out, 16'h1234);
      check("cdb0_pc", pc_out, 16'h0010);
      RE = 1;
      put(16'h0020, 0, 0);
      tick();
      idle();
      #1;
      check("ret0_head", head_addr, 1);
      check("ret0_full", rob_full, 0);
      check("ret0_empty", rob_empty, 0);
      check("ret0_tail", tail_out, 0);
      put(16'h0020, 0, 0);
      tick();
      idle();
      #1;
      check("count7_refill", rob_full, 1);
      check("refill_tail", tail_out, 1);

      cdb_valid = 1; cdb_tag = 2; cdb_value = 16'hAAAA;
      tick();
      cdb_tag = 1; cdb_value = 16'hBBBB;
      tick();
      idle();
      #1;
      check("ooo1_head", head_addr, 1);
      check("ooo1_valid", valid_out, 1);
      check("ooo1_value", value_out, 16'hBBBB);
      check("ooo1_pc", pc_out, 16'h0012);
      check("ooo1_opcode", opcode_out, 1);
      RE = 1;
      tick();
      idle();
      #1;
      check("ooo2_head", head_addr, 2);
      check("ooo2_valid", valid_out, 1);
      check("ooo2_value", value_out, 16'hAAAA);
      check("ooo2_pc", pc_out, 16'h0014);
      check("ooo2_dest", dest_out, 2);
      RE = 1;
      tick();
      idle();
      #1;
      check("head3", head_addr, 3);
      check("head3_valid", valid_out, 0);

      cdb_valid = 1; cdb_tag = 3; cdb_value = 16'h00FF;
      #1;
`ifdef ROB_CDB_BYPASS_EN
      check("byp_valid", valid_out, 1);
      check("byp_value", value_out, 16'h00FF);
`else
      check("nobyp_valid", valid_out, 0);
`endif
      tick();
      idle();
      #1;
      check("cdb3_valid", valid_out, 1);
      check("cdb3_value", value_out, 16'h00FF);

      RE = 1;
      tick();
      tick();
      idle();
      #1;
      check("unready_ret_head", head_addr, 5);
      check("unready_ret_valid", valid_out, 0);
      put(16'h0030, 0, 0);
      #1;
      check("pre_flush_tag", tail_out, 1);
      tick();

      idle();
      flush = 1;
      cdb_valid = 1; cdb_tag = 5; cdb_value = 16'h5555;
      put(16'h0032, 1, 16'h7777);
      tick();
      idle();
      #1;
      check("flush_empty", rob_empty, 1);
      check("flush_head", head_addr, 0);
      check("flush_tail", tail_out, 0);
      check("flush_valid", valid_out, 0);
      RE = 1;
      tick();
      idle();
      #1;
      check("re_empty_head", head_addr, 0);
      check("re_empty_empty", rob_empty, 1);

      put(16'h0040, 1, 16'h0200);
      tick();
      for (int k = 1; k < 5; k++) begin
         put(16'h0040 + 16'(2 * k), 1, 16'h0200 + 16'(k));
         RE = 1;
         #1;
         check("b2b_valid", valid_out, 1);
         check("b2b_value", value_out, 16'h0200 + k - 1);
         tick();
      end
      idle();
      RE = 1;
      tick();
      idle();
      #1;
      check("b2b_empty", rob_empty, 1);
      check("b2b_head", head_addr, 5);
      check("b2b_tail", tail_out, 5);

      for (int k = 5; k < 8; k++) begin
         put(16'h0050 + 16'(k), 0, 0);
         #1;
         check("wrap_tag", tail_out, k);
         tick();
      end
      idle();
      #1;
      check("wrap_tail", tail_out, 0);
      check("wrap_head", head_addr, 5);
      check("wrap_valid", valid_out, 0);
      check("wrap_full", rob_full, 0);
      for (int k = 0; k < 4; k++) begin
         put(16'h0060 + 16'(k), 0, 0);
         tick();
      end
      idle();
      #1;
      check("wrap_count7", rob_full, 0);
      put(16'h0070, 0, 0);
      tick();
      idle();
      #1;
      check("wrap_count8", rob_full, 1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
